// File: rtl/cache_wb_dm.sv
// cache_wb_dm: direct-mapped, write-back, write-allocate data cache with
// multi-word lines, sitting between the core memory stage and main memory.
//
// Ports
//   clk, reset            single clock; synchronous active-high reset
//   cpu_req/cpu_we        core access request (sampled in IDLE) and direction
//   cpu_addr/cpu_wdata    byte address and write data of the access
//   cpu_rdata/cpu_ready   read data and one-cycle completion pulse
//   hit                   pulses with cpu_ready when the first lookup hit
//   mem_req/mem_we        block transfer request; 1=writeback, 0=refill
//   mem_addr              block-aligned address of the transfer
//   mem_wdata/mem_rdata   whole block, word 0 in bits [31:0]
//   mem_ready             transfer complete (only looked at while mem_req=1)
//   hit_count/miss_count  saturating access statistics
module cache_wb_dm #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LINES       = 512,
  parameter int unsigned BLOCK_WORDS = 4,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [ADDR_W-1:0]         cpu_addr,
  input  logic [31:0]               cpu_wdata,
  output logic [31:0]               cpu_rdata,
  output logic                      cpu_ready,
  output logic                      hit,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [32*BLOCK_WORDS-1:0] mem_wdata,
  input  logic [32*BLOCK_WORDS-1:0] mem_rdata,
  input  logic                      mem_ready,
  output logic [CNT_W-1:0]          hit_count,
  output logic [CNT_W-1:0]          miss_count
);

  localparam int unsigned OFF_W  = $clog2(BLOCK_WORDS);
  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W - 2;
  localparam int unsigned WSEL_W = (OFF_W == 0) ? 1 : OFF_W;
  localparam int unsigned BLK_W  = 32 * BLOCK_WORDS;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COMPARE,
    S_WRITEBACK,
    S_ALLOCATE
  } state_t;

  state_t r_state, w_next;

  // Latched request
  logic              r_we;
  logic [ADDR_W-1:2] r_addr;
  logic [31:0]       r_wdata;
  logic              r_miss;

  // Line state and storage
  logic [LINES-1:0]  r_valid;
  logic [LINES-1:0]  r_dirty;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [BLK_W-1:0]  r_data [LINES];

  logic [CNT_W-1:0]  r_hit_cnt;
  logic [CNT_W-1:0]  r_miss_cnt;

  logic [TAG_W-1:0]  w_tag;
  logic [IDX_W-1:0]  w_idx;
  logic [WSEL_W-1:0] w_word;
  logic [TAG_W-1:0]  w_line_tag;
  logic [BLK_W-1:0]  w_line;
  logic              w_hit;
  logic [31:0]       w_word_data;
  logic [1:0]        w_unused_byte;

  assign w_unused_byte = cpu_addr[1:0];
  assign w_tag         = r_addr[ADDR_W-1 -: TAG_W];
  assign w_idx         = r_addr[OFF_W+2 +: IDX_W];

  generate
    if (OFF_W == 0) begin : g_one_word
      assign w_word = '0;
    end else begin : g_multi_word
      assign w_word = r_addr[2 +: OFF_W];
    end
  endgenerate

  assign w_line_tag  = r_tag[w_idx];
  assign w_line      = r_data[w_idx];
  assign w_hit       = r_valid[w_idx] && (w_line_tag == w_tag);
  assign w_word_data = w_line[32*w_word +: 32];

  assign hit_count  = r_hit_cnt;
  assign miss_count = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    cpu_ready = 1'b0;
    hit       = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu_req) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        if (w_hit) begin
          // After a refill the second lookup always hits; r_miss keeps the
          // response honest about the original outcome.
          cpu_ready = 1'b1;
          hit       = !r_miss;
          cpu_rdata = w_word_data;
          w_next    = S_IDLE;
        end else if (r_valid[w_idx] && r_dirty[w_idx]) begin
          w_next = S_WRITEBACK;
        end else begin
          w_next = S_ALLOCATE;
        end
      end
      S_WRITEBACK: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {w_line_tag, w_idx, {(OFF_W+2){1'b0}}};
        mem_wdata = w_line;
        if (mem_ready) w_next = S_ALLOCATE;
      end
      S_ALLOCATE: begin
        mem_req  = 1'b1;
        mem_addr = {w_tag, w_idx, {(OFF_W+2){1'b0}}};
        if (mem_ready) w_next = S_COMPARE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && cpu_req) begin
      r_we    <= cpu_we;
      r_addr  <= cpu_addr[ADDR_W-1:2];
      r_wdata <= cpu_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_miss <= 1'b0;
    end else if (r_state == S_IDLE && cpu_req) begin
      r_miss <= 1'b0;
    end else if (r_state == S_COMPARE && !w_hit) begin
      r_miss <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (r_state == S_ALLOCATE && mem_ready) begin
      r_valid[w_idx] <= 1'b1;
      r_dirty[w_idx] <= 1'b0;
    end else if (r_state == S_COMPARE && w_hit && r_we) begin
      r_dirty[w_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; writes are still blocked while reset is
  // high so a late mem_ready cannot land a refill.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (r_state == S_ALLOCATE && mem_ready) begin
        r_data[w_idx] <= mem_rdata;
        r_tag[w_idx]  <= w_tag;
      end else if (r_state == S_COMPARE && w_hit && r_we) begin
        r_data[w_idx][32*w_word +: 32] <= r_wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (cpu_ready) begin
      if (r_miss) begin
        if (r_miss_cnt != '1) r_miss_cnt <= r_miss_cnt + CNT_ONE;
      end else begin
        if (r_hit_cnt != '1) r_hit_cnt <= r_hit_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: doc/cache_wb_dm.md
Name: cache_wb_dm

Overview:
- Parametrised direct-mapped, write-back, write-allocate data cache with multi-word blocks.
- Sits between the core's memory stage and the main-memory model.
- Handshakes on both sides: the core stalls on `cpu_ready`; memory transfers whole blocks under `mem_req`/`mem_ready`.
- Provides dirty-block eviction and hit/miss statistics counters.

Parameters:
- ADDR_W, 32, address width in bits.
- LINES, 512, number of cache lines; power of two, ≥2.
- BLOCK_WORDS, 4, 32-bit words per line; power of two, ≥1.
- CNT_W, 32, width of the hit and miss statistics counters.
- Derived: OFF_W=log2(BLOCK_WORDS), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W-2.
- Address split: tag=[ADDR_W-1 : IDX_W+OFF_W+2], index=[IDX_W+OFF_W+1 : OFF_W+2], word=[OFF_W+1:2], byte=[1:0] (ignored).
- Defaults give 8 KB of data.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  access request; sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  write data.
- cpu_rdata  out  32  read data; valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- hit  out  1  pulses with cpu_ready when the original lookup hit.
- mem_req  out  1  block transfer request.
- mem_we  out  1  1=writeback, 0=refill.
- mem_addr  out  ADDR_W  block-aligned address; low OFF_W+2 bits are 0.
- mem_wdata  out  32*BLOCK_WORDS  block being written back; word 0 in bits [31:0].
- mem_rdata  in  32*BLOCK_WORDS  refill block; same word ordering.
- mem_ready  in  1  transfer done; sampled only while mem_req=1.
- hit_count  out  CNT_W  saturating count of hit accesses.
- miss_count  out  CNT_W  saturating count of miss accesses.

Behaviour:
- Reset:
  - State=IDLE; all valid and dirty bits cleared in one cycle.
  - Outputs cpu_ready, hit, mem_req, mem_we, hit_count and miss_count are 0.
  - cpu_rdata, mem_addr and mem_wdata are 0.
  - Tag/data arrays are not cleared.
- Reset mid-transaction:
  - mem_req drops the cycle after reset is asserted; dirty data in flight is discarded.
  - A mem_ready arriving during or after reset is ignored.
- IDLE:
  - On cpu_req=1, latch cpu_we, cpu_addr and cpu_wdata, then go to COMPARE.
  - Requests outside IDLE are ignored; the core holds its request until cpu_ready.
- COMPARE (hit = valid[idx] && tag[idx]==req_tag):
  - Read hit: cpu_rdata=data[idx][word]; cpu_ready=1 and hit=1 for this cycle; go to IDLE.
  - Write hit: write the word; dirty[idx]=1; cpu_ready=1 and hit=1; go to IDLE.
  - Hit latency is 1 cycle after acceptance; back-to-back accesses allow a new request every 2 cycles.
  - Miss with valid && dirty: go to WRITEBACK. Miss otherwise: go to ALLOCATE.
  - Miss flag is held so the final response reports hit=0.
- WRITEBACK:
  - mem_req=1, mem_we=1, mem_addr={tag[idx], idx, 0}, mem_wdata=data[idx].
  - All outputs are held stable until mem_ready, then go to ALLOCATE.
- ALLOCATE:
  - mem_req=1, mem_we=0, mem_addr={req_tag, idx, 0}.
  - On mem_ready: data[idx]=mem_rdata, tag[idx]=req_tag, valid=1, dirty=0; go to COMPARE.
  - The second COMPARE hits and completes the access: cpu_ready=1, hit=0. A write then sets dirty.
  - mem_req=0 on the cycle after mem_ready. Memory may assert mem_ready in the same cycle mem_req rises (zero wait).
- Counters:
  - Incremented once per access at its cpu_ready: hit_count on a hit, miss_count on a miss.
  - Both saturate at all-ones.
- mem_req is never asserted in IDLE or COMPARE. There is never more than one outstanding memory transfer.

Test Plan:
- Reset, then read 0x0000_1004 with mem_ready 3 cycles after mem_req → one refill at mem_addr 0x0000_1000, mem_we=0; cpu_rdata = word 1 of mem_rdata; hit=0; miss_count=1.
- Write 0xDEADBEEF to 0x0000_1008, then read 0x0000_1008 → both complete 1 cycle after acceptance with hit=1; no mem_req; rdata=0xDEADBEEF; hit_count=2.
- Read 0x0000_3004 (same index 0x100, tag 1) → WRITEBACK at 0x0000_1000 with word 2=0xDEADBEEF, then refill at 0x0000_3000; response hit=0.
- Write miss to the clean line 0x0000_5000 → no writeback, refill only; line dirty afterwards; a following read returns the written word with hit=1.
- Assert reset during ALLOCATE wait, then pulse mem_ready → mem_req=0 the next cycle; no cpu_ready; re-read of 0x0000_1004 misses.
- Preload hit_count to all-ones (CNT_W=4, 16 hits) → count stays 0xF.
